i2c_target: RTL



---
 rtl/i2c_pkg.sv | 20 ++
 rtl/i2c_target_if.sv | 26 ++
 rtl/i2c_bus_sync.sv | 44 ++++
 rtl/i2c_target.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM state encoding (one-hot, bit-index order shared with
// the controller) and the byte width used by the shifters.
package i2c_pkg;

    localparam int unsigned BitsPerByte = 8;

    typedef enum logic [9:0] {
        StIdle     = 10'b00_0000_0001,
        StAddr     = 10'b00_0000_0010,
        StAddrAck  = 10'b00_0000_0100,
        StPtr      = 10'b00_0000_1000,
        StPtrAck   = 10'b00_0001_0000,
        StWdata    = 10'b00_0010_0000,
        StWdataAck = 10'b00_0100_0000,
        StRdata    = 10'b00_1000_0000,
        StRdataAck = 10'b01_0000_0000,
        StIgnore   = 10'b10_0000_0000
    } i2c_state_e;

endpackage

// File: rtl/i2c_target_if.sv
// Host-side port bundle of the I2C target: status, write strobes and the register side-read port.
interface i2c_target_if #(
    parameter int unsigned REG_DEPTH = 16
);
    import i2c_pkg::*;

    localparam int unsigned AW = $clog2(REG_DEPTH);

    logic                   Busy;
    logic                   Wr_strobe;
    logic [AW-1:0]          Wr_addr;
    logic [BitsPerByte-1:0] Wr_data;
    logic [AW-1:0]          Host_addr;
    logic [BitsPerByte-1:0] Host_data;

    modport master (
        input  Busy, Wr_strobe, Wr_addr, Wr_data, Host_data,
        output Host_addr
    );

    modport slave (
        output Busy, Wr_strobe, Wr_addr, Wr_data, Host_data,
        input  Host_addr
    );

endinterface

// File: rtl/i2c_bus_sync.sv
// Two-flop SCL/SDA synchronizer with registered SCL edge and START/STOP pulses.
module i2c_bus_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic scl,
    input  logic sda,
    output logic sda_bit,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    // [0],[1] synchronizer stages, [2] previous synchronized sample; idle bus is high
    logic [2:0] scl_q;
    logic [2:0] sda_q;
    logic       scl_chg;
    logic       sda_chg;

    assign scl_chg = scl_q[1] ^ scl_q[2];
    assign sda_chg = sda_q[1] ^ sda_q[2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_q    <= '1;
            sda_q    <= '1;
            sda_bit  <= 1'b1;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            start    <= 1'b0;
            stop     <= 1'b0;
        end else begin
            scl_q    <= {scl_q[1:0], scl};
            sda_q    <= {sda_q[1:0], sda};
            sda_bit  <= sda_q[1];
            // Simultaneous SCL and SDA change is ambiguous: no sample, no START/STOP
            scl_rise <= scl_q[1] & ~scl_q[2] & ~sda_chg;
            scl_fall <= ~scl_q[1] & scl_q[2];
            start    <= scl_q[1] & scl_q[2] & ~scl_chg & ~sda_q[1] & sda_q[2];
            stop     <= scl_q[1] & scl_q[2] & ~scl_chg & sda_q[1] & ~sda_q[2];
        end
    end

endmodule

// File: rtl/i2c_target.sv
// I2C target endpoint with a byte-wide register file and host side-read port.
// Define I2C_TGT_AUTOINC_EN to auto-increment the register pointer on data bytes.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR  = 7'h42,
    parameter int unsigned REG_DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         SCL,
    inout  wire          SDA,
    i2c_target_if.slave  host
);

    localparam int unsigned AW = $clog2(REG_DEPTH);

`ifdef I2C_TGT_AUTOINC_EN
    localparam bit AutoInc = 1'b1;
`else
    localparam bit AutoInc = 1'b0;
`endif

    logic sda_bit, scl_rise, scl_fall, start, stop;

    i2c_bus_sync u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .scl      (SCL),
        .sda      (SDA),
        .sda_bit  (sda_bit),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    logic [BitsPerByte-1:0] regs_q [REG_DEPTH];
    i2c_state_e             state_q;
    logic [3:0]             bit_cnt_q;
    logic [BitsPerByte-1:0] shift_q;
    logic [AW-1:0]          ptr_q;
    logic                   rw_q, nack_q, sda_oe_q, busy_q, wr_strobe_q;
    logic [AW-1:0]          wr_addr_q;
    logic [BitsPerByte-1:0] wr_data_q, host_data_q;

    logic [BitsPerByte-1:0] rx_byte;
    logic [AW-1:0]          ptr_inc, rd_ptr;
    logic                   byte_done;

    assign rx_byte   = {shift_q[BitsPerByte-2:0], sda_bit};
    assign ptr_inc   = ptr_q + AW'(1);
    assign rd_ptr    = AutoInc ? ptr_inc : ptr_q;
    assign byte_done = (bit_cnt_q == 4'(BitsPerByte));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            rw_q        <= 1'b0;
            nack_q      <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            for (int unsigned i = 0; i < REG_DEPTH; i++) regs_q[i] <= '0;
        end else begin
            wr_strobe_q <= 1'b0;
            if (start) begin
                state_q   <= StAddr;
                bit_cnt_q <= '0;
                sda_oe_q  <= 1'b0;
            end else if (stop) begin
                state_q   <= StIdle;
                bit_cnt_q <= '0;
                sda_oe_q  <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle, StIgnore: ;
                    StAddr: begin
                        if (scl_rise) begin
                            shift_q   <= rx_byte;
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall && byte_done) begin
                            bit_cnt_q <= '0;
                            if (shift_q[7:1] == DEV_ADDR) begin
                                state_q  <= StAddrAck;
                                sda_oe_q <= 1'b1;
                                busy_q   <= 1'b1;
                                rw_q     <= shift_q[0];
                            end else begin
                                state_q <= StIgnore;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    StAddrAck: begin
                        if (scl_fall) begin
                            if (rw_q) begin
                                shift_q  <= regs_q[ptr_q];
                                sda_oe_q <= ~regs_q[ptr_q][7];
                                state_q  <= StRdata;
                            end else begin
                                sda_oe_q <= 1'b0;
                                state_q  <= StPtr;
                            end
                        end
                    end
                    StPtr: begin
                        if (scl_rise) begin
                            shift_q   <= rx_byte;
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall && byte_done) begin
                            ptr_q     <= shift_q[AW-1:0];
                            bit_cnt_q <= '0;
                            sda_oe_q  <= 1'b1;
                            state_q   <= StPtrAck;
                        end
                    end
                    StPtrAck, StWdataAck: begin
                        if (scl_fall) begin
                            sda_oe_q <= 1'b0;
                            state_q  <= StWdata;
                        end
                    end
                    StWdata: begin
                        if (scl_rise) begin
                            shift_q   <= rx_byte;
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'(BitsPerByte - 1)) begin
                                regs_q[ptr_q] <= rx_byte;
                                wr_strobe_q   <= 1'b1;
                                wr_addr_q     <= ptr_q;
                                wr_data_q     <= rx_byte;
                                if (AutoInc) ptr_q <= ptr_inc;
                            end
                        end else if (scl_fall && byte_done) begin
                            bit_cnt_q <= '0;
                            sda_oe_q  <= 1'b1;
                            state_q   <= StWdataAck;
                        end
                    end
                    StRdata: begin
                        if (scl_rise) begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall) begin
                            if (byte_done) begin
                                bit_cnt_q <= '0;
                                sda_oe_q  <= 1'b0;
                                state_q   <= StRdataAck;
                            end else begin
                                shift_q  <= {shift_q[BitsPerByte-2:0], 1'b0};
                                sda_oe_q <= ~shift_q[BitsPerByte-2];
                            end
                        end
                    end
                    StRdataAck: begin
                        if (scl_rise) begin
                            nack_q <= sda_bit;
                        end else if (scl_fall) begin
                            if (nack_q) begin
                                sda_oe_q <= 1'b0;
                                state_q  <= StIgnore;
                            end else begin
                                ptr_q    <= rd_ptr;
                                shift_q  <= regs_q[rd_ptr];
                                sda_oe_q <= ~regs_q[rd_ptr][7];
                                state_q  <= StRdata;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) host_data_q <= '0;
        else          host_data_q <= regs_q[host.Host_addr];
    end

    // Open drain: only ever pull low or release
    assign SDA            = sda_oe_q ? 1'b0 : 1'bz;
    assign host.Busy      = busy_q;
    assign host.Wr_strobe = wr_strobe_q;
    assign host.Wr_addr   = wr_addr_q;
    assign host.Wr_data   = wr_data_q;
    assign host.Host_data = host_data_q;

endmodule
